vga_sync_timing: RTL

Generates 640x480 @ 60 Hz VGA timing for the display path. Divides the system clock down to a pixel tick and runs horizontal and vertical counters. Drives `PosX`/`PosY`, active-low `HSync`/`VSync`, and the visible-area flag. Its outputs feed the pointer/overlay stage, which uses `PosX`/`PosY` to address the interface and digit ROMs and accepts register writes only while `VSync` is low.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_pixel_tick.sv | 30 +++
 rtl/vga_sync_timing.sv | 87 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz VGA timing constants and the coordinate type used
// by the sync generator and the downstream pointer/overlay stage.
package vga_timing_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Pixel/line coordinate; 10 bits covers both 800 and 525 with no overflow.
  typedef logic [9:0] coord_t;

  // Narrow an elaboration-time integer to a coordinate constant.
  function automatic coord_t to_coord(input int value);
    return coord_t'(value);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel clock-enable generator: divides the system clock by PIX_DIV and
// pulses pix_tick on the last system clock of every pixel period.
module vga_pixel_tick #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic pix_tick
);

  // A one-bit counter that never leaves zero makes PIX_DIV = 1 a constant tick.
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div_cnt;

  // Free-running 0..PIX_DIV-1 counter, restarted by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign pix_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_timing.sv
// VGA raster generator: horizontal/vertical position counters advanced on
// each pixel tick, plus registered sync, visible-area and frame-start flags.
// Flags are decoded from the next-state coordinates so they line up with
// PosX/PosY in the same cycle.
module vga_sync_timing import vga_timing_pkg::*; #(
  parameter int PIX_DIV = 4,
  parameter int H_VIS   = vga_timing_pkg::H_VIS,
  parameter int H_FP    = vga_timing_pkg::H_FP,
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BP    = vga_timing_pkg::H_BP,
  parameter int V_VIS   = vga_timing_pkg::V_VIS,
  parameter int V_FP    = vga_timing_pkg::V_FP,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BP    = vga_timing_pkg::V_BP
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic       HSync,
  output logic       VSync,
  output logic       VideoOn,
  output logic       PixTick,
  output logic       FrameStart
);

  localparam coord_t H_LAST   = to_coord(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = to_coord(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS_C  = to_coord(H_VIS);
  localparam coord_t V_VIS_C  = to_coord(V_VIS);
  localparam coord_t HS_START = to_coord(H_VIS + H_FP);
  localparam coord_t HS_END   = to_coord(H_VIS + H_FP + H_SYNC);
  localparam coord_t VS_START = to_coord(V_VIS + V_FP);
  localparam coord_t VS_END   = to_coord(V_VIS + V_FP + V_SYNC);

  coord_t x_next;
  coord_t y_next;
  logic   frame_wrap;

  vga_pixel_tick #(
    .PIX_DIV (PIX_DIV)
  ) u_pixel_tick (
    .clk      (CLK),
    .reset_n  (RESET),
    .pix_tick (PixTick)
  );

  // Next raster position: advance one pixel per tick, wrapping line and frame.
  always_comb begin
    x_next     = PosX;
    y_next     = PosY;
    frame_wrap = 1'b0;
    if (PixTick) begin
      if (PosX == H_LAST) begin
        x_next = '0;
        if (PosY == V_LAST) begin
          y_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          y_next = PosY + coord_t'(1);
        end
      end else begin
        x_next = PosX + coord_t'(1);
      end
    end
  end

  // Register position and the flags decoded from the same next-state position.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      PosX       <= '0;
      PosY       <= '0;
      HSync      <= 1'b1;
      VSync      <= 1'b1;
      VideoOn    <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      PosX       <= x_next;
      PosY       <= y_next;
      HSync      <= !((x_next >= HS_START) && (x_next < HS_END));
      VSync      <= !((y_next >= VS_START) && (y_next < VS_END));
      VideoOn    <= (x_next < H_VIS_C) && (y_next < V_VIS_C);
      FrameStart <= frame_wrap;
    end
  end

endmodule
